// File: rtl/switch_debouncer.sv
// Synchronises and debounces the slide-switch pins, with per-bit rise/fall strobes.
// Optional sticky change-capture flags are built when SW_DEBOUNCE_CAPTURE_EN is defined.
module switch_debouncer #(
  parameter int unsigned NUM_SW          = 10,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw_clean,
  output logic [NUM_SW-1:0] sw_rise,
  output logic [NUM_SW-1:0] sw_fall,
  output logic              sw_any_change
`ifdef SW_DEBOUNCE_CAPTURE_EN
  ,
  input  logic [NUM_SW-1:0] capture_clr,
  output logic [NUM_SW-1:0] sw_capture
`endif
);

  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_e;

  logic [NUM_SW-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SW-1:0] sync_s;
  state_e            state_q [NUM_SW];
  state_e            state_d [NUM_SW];
  logic [CNT_W-1:0]  cnt_q   [NUM_SW];
  logic [CNT_W-1:0]  cnt_d   [NUM_SW];
  logic [NUM_SW-1:0] accept_c;
  logic [NUM_SW-1:0] clean_d;
  logic [NUM_SW-1:0] rise_d;
  logic [NUM_SW-1:0] fall_d;

  // Plain flop chain into the clock domain; nothing sits between stages.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= sw_raw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Per-bit state and stability counter.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_SW; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SW; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next state: a disagreement must persist DEBOUNCE_CYCLES samples to be accepted.
  always_comb begin
    for (int i = 0; i < NUM_SW; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      accept_c[i] = 1'b0;
      case (state_q[i])
        ST_STABLE: begin
          if (sync_s[i] != sw_clean[i]) begin
            state_d[i] = ST_COUNTING;
            cnt_d[i]   = CNT_W'(1);
          end else begin
            cnt_d[i] = '0;
          end
        end
        ST_COUNTING: begin
          if (sync_s[i] == sw_clean[i]) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            accept_c[i] = 1'b1;
            state_d[i]  = ST_STABLE;
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Outputs: an accepted bit flips its clean level and emits the matching strobe.
  always_comb begin
    clean_d = sw_clean ^ accept_c;
    rise_d  = accept_c & ~sw_clean;
    fall_d  = accept_c & sw_clean;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sw_clean      <= '0;
      sw_rise       <= '0;
      sw_fall       <= '0;
      sw_any_change <= 1'b0;
    end else begin
      sw_clean      <= clean_d;
      sw_rise       <= rise_d;
      sw_fall       <= fall_d;
      sw_any_change <= |accept_c;
    end
  end

`ifdef SW_DEBOUNCE_CAPTURE_EN
  // Sticky change flags; a strobe in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sw_capture <= '0;
    end else begin
      sw_capture <= (sw_capture & ~capture_clr) | sw_rise | sw_fall;
    end
  end
`endif

endmodule
